// File: rtl/writeback_queue.sv
// Circular writeback FIFO feeding a single register-file write port, with optional
// combinational bypass lookup over pending entries (enable with macro WBQ_BYPASS_EN).
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [4:0]               i_in_reg_num,
  input  logic [31:0]              i_in_data,
  input  logic                     i_drain_enable,
  output logic [4:0]               o_write_reg_num_1,
  output logic [31:0]              o_write_data,
  output logic                     o_regwrite,
  input  logic [4:0]               i_read_reg_num_1,
  input  logic [4:0]               i_read_reg_num_2,
  output logic                     o_bypass_hit_1,
  output logic                     o_bypass_hit_2,
  output logic [31:0]              o_bypass_data_1,
  output logic [31:0]              o_bypass_data_2,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    r_mem_reg_num [DEPTH];
  logic [31:0]   r_mem_data    [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [4:0]    r_write_reg_num;
  logic [31:0]   r_write_data;
  logic          r_regwrite;

  logic w_in_ready;
  logic w_accept;
  logic w_push;
  logic w_pop;

  // Ready depends only on registered occupancy, so a same-edge pop never frees a slot.
  assign w_in_ready = (r_count != CW'(DEPTH));
  assign w_accept   = i_in_valid & w_in_ready;
  // Writes to r0 complete the handshake but are dropped.
  assign w_push     = w_accept & (i_in_reg_num != 5'd0);
  assign w_pop      = i_drain_enable & (r_count != '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_reg_num[r_wr_ptr] <= i_in_reg_num;
      r_mem_data[r_wr_ptr]    <= i_in_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_write_reg_num <= '0;
      r_write_data    <= '0;
      r_regwrite      <= 1'b0;
    end else begin
      r_regwrite <= w_pop;
      if (w_pop) begin
        r_write_reg_num <= r_mem_reg_num[r_rd_ptr];
        r_write_data    <= r_mem_data[r_rd_ptr];
      end
    end
  end

  assign o_in_ready        = w_in_ready;
  assign o_write_reg_num_1 = r_write_reg_num;
  assign o_write_data      = r_write_data;
  assign o_regwrite        = r_regwrite;
  assign o_count           = r_count;

`ifdef WBQ_BYPASS_EN
  logic [4:0] w_rd_addr [2];
  assign w_rd_addr[0] = i_read_reg_num_1;
  assign w_rd_addr[1] = i_read_reg_num_2;

  for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
    logic        w_hit;
    logic [31:0] w_data;
    // Walk from oldest to newest so the most recently accepted match wins.
    always_comb begin
      w_hit  = 1'b0;
      w_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
        if ((CW'(k) < r_count) && (w_rd_addr[gi] != 5'd0) &&
            (r_mem_reg_num[r_rd_ptr + AW'(k)] == w_rd_addr[gi])) begin
          w_hit  = 1'b1;
          w_data = r_mem_data[r_rd_ptr + AW'(k)];
        end
      end
    end
  end

  assign o_bypass_hit_1  = g_bypass[0].w_hit;
  assign o_bypass_hit_2  = g_bypass[1].w_hit;
  assign o_bypass_data_1 = g_bypass[0].w_data;
  assign o_bypass_data_2 = g_bypass[1].w_data;
`else
  logic w_unused_read_addr;
  assign w_unused_read_addr = ^{i_read_reg_num_1, i_read_reg_num_2};

  assign o_bypass_hit_1  = 1'b0;
  assign o_bypass_hit_2  = 1'b0;
  assign o_bypass_data_1 = 32'h0;
  assign o_bypass_data_2 = 32'h0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed self-checking bench for writeback_queue (DEPTH=4); bypass expectations
// follow whether WBQ_BYPASS_EN is defined.
module tb_writeback_queue;

  localparam int DEPTH = 4;
`ifdef WBQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg_num;
  logic [31:0] in_data;
  logic        drain_enable;
  logic [4:0]  write_reg_num_1;
  logic [31:0] write_data;
  logic        regwrite;
  logic [4:0]  read_reg_num_1;
  logic [4:0]  read_reg_num_2;
  logic        bypass_hit_1;
  logic        bypass_hit_2;
  logic [31:0] bypass_data_1;
  logic [31:0] bypass_data_2;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_in_valid        (in_valid),
    .o_in_ready        (in_ready),
    .i_in_reg_num      (in_reg_num),
    .i_in_data         (in_data),
    .i_drain_enable    (drain_enable),
    .o_write_reg_num_1 (write_reg_num_1),
    .o_write_data      (write_data),
    .o_regwrite        (regwrite),
    .i_read_reg_num_1  (read_reg_num_1),
    .i_read_reg_num_2  (read_reg_num_2),
    .o_bypass_hit_1    (bypass_hit_1),
    .o_bypass_hit_2    (bypass_hit_2),
    .o_bypass_data_1   (bypass_data_1),
    .o_bypass_data_2   (bypass_data_2),
    .o_count           (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_reg_num = '0;
    in_data = '0;
    drain_enable = 1'b0;
    read_reg_num_1 = '0;
    read_reg_num_2 = '0;

    // Reset state
    tick();
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_regwrite", 32'(regwrite), 32'd0);
    chk("rst_wr_reg", 32'(write_reg_num_1), 32'd0);
    chk("rst_wr_data", write_data, 32'd0);
    chk("rst_hit1", 32'(bypass_hit_1), 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    $display("txn reset count=%0d in_ready=%0b", count, in_ready);

    // Single request r5 <- 1 with drain enabled
    drain_enable = 1'b1;
    in_valid = 1'b1; in_reg_num = 5'd5; in_data = 32'h1;
    tick();
    in_valid = 1'b0;
    chk("lat_no_pass", 32'(regwrite), 32'd0);
    chk("lat_count1", 32'(count), 32'd1);
    tick();
    chk("lat_regwrite", 32'(regwrite), 32'd1);
    chk("lat_wr_reg", 32'(write_reg_num_1), 32'd5);
    chk("lat_wr_data", write_data, 32'h1);
    chk("lat_count0", 32'(count), 32'd0);
    tick();
    chk("lat_one_cycle", 32'(regwrite), 32'd0);
    chk("lat_hold_reg", 32'(write_reg_num_1), 32'd5);
    $display("txn single r5 write done");

    // Fill to full with drain stalled, fifth offer rejected
    drain_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_reg_num = 5'(8 + i); in_data = 32'h80 + 32'(i);
      #1;
      chk("fill_ready", 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
      $display("txn offer r%0d count=%0d", 8 + i, count);
    end
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_no_write", 32'(regwrite), 32'd0);
    // Pop while full with r12 still offered: must not be accepted on that edge
    drain_enable = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("full_pop_count", 32'(count), 32'd3);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      chk("drain_regwrite", 32'(regwrite), 32'd1);
      chk("drain_reg", 32'(write_reg_num_1), 32'(8 + k));
      chk("drain_data", write_data, 32'h80 + 32'(k));
      $display("txn drain r%0d data=%h", write_reg_num_1, write_data);
    end
    tick();
    chk("drain_empty_rw", 32'(regwrite), 32'd0);
    chk("drain_empty_cnt", 32'(count), 32'd0);
    in_valid = 1'b1; in_reg_num = 5'd12; in_data = 32'h84;
    tick();
    in_valid = 1'b0;
    tick();
    chk("r12_regwrite", 32'(regwrite), 32'd1);
    chk("r12_reg", 32'(write_reg_num_1), 32'd12);
    chk("r12_data", write_data, 32'h84);
    tick();
    chk("r12_done", 32'(regwrite), 32'd0);
    $display("txn reoffer r12 written");

    // Bypass: two pending writes to r9, newest wins
    drain_enable = 1'b0;
    in_valid = 1'b1; in_reg_num = 5'd9; in_data = 32'h7;
    tick();
    in_data = 32'hA;
    tick();
    in_valid = 1'b0;
    read_reg_num_1 = 5'd9; read_reg_num_2 = 5'd0;
    #1;
    chk("byp_hit1", 32'(bypass_hit_1), BYP ? 32'd1 : 32'd0);
    chk("byp_data1", bypass_data_1, BYP ? 32'hA : 32'h0);
    chk("byp_hit2_r0", 32'(bypass_hit_2), 32'd0);
    chk("byp_data2_r0", bypass_data_2, 32'h0);
    read_reg_num_2 = 5'd3;
    #1;
    chk("byp_miss2", 32'(bypass_hit_2), 32'd0);
    $display("txn bypass r9 hit=%0b data=%h", bypass_hit_1, bypass_data_1);
    drain_enable = 1'b1;
    tick();
    chk("byp_pop1_data", write_data, 32'h7);
    #1;
    chk("byp_after_pop", bypass_data_1, BYP ? 32'hA : 32'h0);
    tick();
    chk("byp_pop2_data", write_data, 32'hA);
    chk("byp_empty_hit", 32'(bypass_hit_1), 32'd0);
    tick();
    read_reg_num_1 = '0; read_reg_num_2 = '0;

    // Write to r0 is swallowed
    in_valid = 1'b1; in_reg_num = 5'd0; in_data = 32'hFFFF_FFFF;
    #1;
    chk("r0_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("r0_count", 32'(count), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("r0_no_write", 32'(regwrite), 32'd0);
    end
    $display("txn r0 discarded count=%0d", count);

    // Asynchronous reset mid-operation
    drain_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_reg_num = 5'(1 + i); in_data = 32'h100 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    drain_enable = 1'b1;
    tick();
    drain_enable = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_rw", 32'(regwrite), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_regwrite", 32'(regwrite), 32'd0);
    chk("arst_wr_reg", 32'(write_reg_num_1), 32'd0);
    chk("arst_wr_data", write_data, 32'd0);
    tick();
    reset = 1'b0;
    drain_enable = 1'b1;
    read_reg_num_1 = 5'd2;
    #1;
    chk("arst_byp", 32'(bypass_hit_1), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("arst_no_write", 32'(regwrite), 32'd0);
      chk("arst_cnt", 32'(count), 32'd0);
    end
    read_reg_num_1 = '0;
    $display("txn async reset discarded pending entries");

    // Streaming accept+drain over 3*DEPTH requests (pointer wrap)
    in_valid = 1'b1; in_reg_num = 5'd1; in_data = 32'h1000;
    tick();
    for (int j = 1; j < 3 * DEPTH; j++) begin
      in_reg_num = 5'((j % 31) + 1); in_data = 32'h1000 + 32'(j);
      tick();
      chk("wrap_count", 32'(count), 32'd1);
      chk("wrap_rw", 32'(regwrite), 32'd1);
      chk("wrap_reg", 32'(write_reg_num_1), 32'(((j - 1) % 31) + 1));
      chk("wrap_data", write_data, 32'h1000 + 32'(j - 1));
      $display("txn stream r%0d data=%h", write_reg_num_1, write_data);
    end
    in_valid = 1'b0;
    tick();
    chk("wrap_last_reg", 32'(write_reg_num_1), 32'(((3 * DEPTH - 1) % 31) + 1));
    chk("wrap_last_data", write_data, 32'h1000 + 32'(3 * DEPTH - 1));
    chk("wrap_end_cnt", 32'(count), 32'd0);
    tick();
    chk("wrap_end_rw", 32'(regwrite), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of pending write entries (power of two, 2..16).
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 In_Valid  input  1  producer offers a writeback request this cycle.
REQ-005 In_Ready  output  1  queue accepts a request this cycle.
REQ-006 In_Reg_Num  input  5  destination register number of the offered request.
REQ-007 In_Data  input  32  write data of the offered request.
REQ-008 Drain_Enable  input  1  register-file write port available this cycle (0 = stall drain).
REQ-009 Write_Reg_Num_1  output  5  register-file write address, registered.
REQ-010 Write_Data  output  32  register-file write data, registered.
REQ-011 RegWrite  output  1  register-file write strobe, registered, one cycle per drained entry.
REQ-012 Read_Reg_Num_1, Read_Reg_Num_2  input  5 each  decode-stage read addresses for bypass lookup.
REQ-013 Bypass_Hit_1, Bypass_Hit_2  output  1 each  matching pending entry exists for the read address.
REQ-014 Bypass_Data_1, Bypass_Data_2  output  32 each  data of the newest matching pending entry, else 0.
REQ-015 Count  output  clog2(DEPTH)+1  number of entries held in the queue.

Function
REQ-016 Queue SHALL be a circular FIFO of DEPTH entries {reg_num[4:0], data[31:0]} with wrapping read/write pointers.
REQ-017 In_Ready SHALL equal (Count != DEPTH), from registered state only; no combinational path from Drain_Enable.
REQ-018 Handshake SHALL complete on a rising edge with In_Valid=1 and In_Ready=1; In_Valid with In_Ready=0 SHALL be ignored, no state change.
REQ-019 An accepted request with In_Reg_Num=0 SHALL be consumed and discarded: no entry stored, Count unchanged, no RegWrite ever produced.
REQ-020 At each rising edge with Drain_Enable=1 and Count>0, head entry SHALL be popped into the output registers with RegWrite=1 for the following cycle.
REQ-021 At each rising edge with Drain_Enable=0 or Count=0, RegWrite SHALL be 0 for the following cycle; Write_Reg_Num_1/Write_Data SHALL hold their last values.
REQ-022 Latency: entry accepted at edge N SHALL be poppable at edge N+1 at earliest (RegWrite high in cycle N+1..N+2); no same-edge pass-through.
REQ-023 Simultaneous accept and pop on one edge SHALL leave Count unchanged; FIFO order SHALL be preserved across pointer wrap.
REQ-024 Because In_Ready uses pre-edge Count, no accept SHALL occur when full even if a pop happens on the same edge.
REQ-025 Bypass lookup SHALL be combinational over queue entries only (not the output register); on multiple matches the most recently accepted entry wins.
REQ-026 Read address 0 SHALL never hit; Bypass_Data SHALL be 0 when the corresponding hit is 0.
REQ-027 Count SHALL never exceed DEPTH nor underflow below 0 under any input sequence.

Reset
REQ-028 Reset=1 SHALL immediately clear pointers, Count=0, RegWrite=0, Write_Reg_Num_1=0, Write_Data=0, independent of Clk.
REQ-029 Reset asserted mid-operation SHALL discard all pending entries without producing any further RegWrite pulse.
REQ-030 Queue entry storage need not be cleared; Bypass outputs SHALL be 0 during and after reset until new entries are accepted.
REQ-031 In_Ready SHALL be 1 in the first cycle after Reset deasserts.

Configuration
REQ-032 Macro WBQ_BYPASS_EN defined: REQ-025/REQ-026 bypass logic compiled in.
REQ-033 WBQ_BYPASS_EN undefined: no comparators instantiated; Bypass_Hit_1/2 tied 0, Bypass_Data_1/2 tied 32'h0; all other behaviour identical.

Verification
REQ-034 Reset, then accept {r5, 32'h0000_0001} with Drain_Enable=1 -> RegWrite=1, Write_Reg_Num_1=5, Write_Data=32'h1 exactly one cycle, after one intervening edge.
REQ-035 Drain_Enable=0, offer 5 requests r8..r12 with DEPTH=4 -> first 4 accepted, In_Ready=0, Count=4; raise Drain_Enable -> writes r8,r9,r10,r11 in order, one per cycle, then r12 once re-offered.
REQ-036 Drain_Enable=0, accept {r9,32'h7} then {r9,32'hA}, Read_Reg_Num_1=9 -> Bypass_Hit_1=1, Bypass_Data_1=32'hA; Read_Reg_Num_2=0 -> Bypass_Hit_2=0 (WBQ_BYPASS_EN defined).
REQ-037 Accept {r0,32'hFFFF_FFFF} -> Count stays 0, no RegWrite pulse within 4 cycles.
REQ-038 Count=3, Drain_Enable=0, assert Reset between edges -> Count=0, RegWrite=0 immediately; no RegWrite over next 4 cycles with Drain_Enable=1.
REQ-039 Continuous accept and drain for 3*DEPTH requests (pointer wrap) -> Count constant at 1, write sequence equals accept sequence exactly.
